// File: rtl/morph_window_ctrl_if.sv
// Handshake and timing bundle between the pixel source and the morphology window sequencer.
// master = pixel source side, slave = sequencer side.
interface morph_window_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [1:0]  cfg_mode;
  logic        pix_en;
  logic        pad;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic [2:0]  line_wr;
  logic        out_valid;
  logic [10:0] out_hpos;
  logic [10:0] out_vpos;
  logic [1:0]  mode_active;
  logic        frame_done;
  logic        sof_err;

  modport master (
    output in_valid, in_sof, cfg_mode,
    input  in_ready, pix_en, pad, hpos, vpos, line_wr, out_valid,
           out_hpos, out_vpos, mode_active, frame_done, sof_err
  );

  modport slave (
    input  in_valid, in_sof, cfg_mode,
    output in_ready, pix_en, pad, hpos, vpos, line_wr, out_valid,
           out_hpos, out_vpos, mode_active, frame_done, sof_err
  );
endinterface

// File: rtl/morph_window_ctrl.sv
// Sequencer for the binary dilate/erode window stage: raster counters, line-buffer slot,
// output coordinate timing, end-of-frame drain of the last window rows and per-frame mode latch.
module morph_window_ctrl #(
  parameter int H_IMG_RES = 640,
  parameter int V_IMG_RES = 480,
  parameter int WIN_SIZE  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  morph_window_ctrl_if.slave bus
);
  localparam int          LAG        = WIN_SIZE / 2 + 1;
  localparam logic [10:0] H_LAST     = 11'(H_IMG_RES - 1);
  localparam logic [10:0] V_LAST     = 11'(V_IMG_RES - 1);
  localparam logic [10:0] FILL_LAST  = 11'(LAG - 1);
  localparam logic [10:0] FLUSH_LAST = 11'(V_IMG_RES + LAG - 1);
  localparam logic [10:0] LAG_W      = 11'(LAG);
  localparam logic [2:0]  LW_LAST    = 3'(WIN_SIZE);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  state_t      r_state, w_state_next;
  logic [10:0] r_hpos, r_vpos, w_hpos_next, w_vpos_next, w_hpos_cur, w_vpos_cur;
  logic [2:0]  r_line_wr, w_line_wr_next, w_line_wr_cur;
  logic [1:0]  r_mode, w_mode_next;
  logic        w_ready, w_xfer, w_sof_xfer, w_pix_en, w_row_end;

  assign w_ready    = (r_state == IDLE) || (r_state == FILL) || (r_state == RUN);
  assign w_xfer     = bus.in_valid & w_ready;
  assign w_sof_xfer = w_xfer & bus.in_sof;

  // An accepted SOF pixel is always (0,0) in slot 0, even when it cuts a frame short.
  assign w_hpos_cur    = w_sof_xfer ? 11'd0 : r_hpos;
  assign w_vpos_cur    = w_sof_xfer ? 11'd0 : r_vpos;
  assign w_line_wr_cur = w_sof_xfer ? 3'd0  : r_line_wr;
  assign w_row_end     = (w_hpos_cur == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hpos    <= '0;
      r_vpos    <= '0;
      r_line_wr <= '0;
      r_mode    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_hpos    <= w_hpos_next;
      r_vpos    <= w_vpos_next;
      r_line_wr <= w_line_wr_next;
      r_mode    <= w_mode_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pix_en       = 1'b0;
    bus.pad        = 1'b0;
    bus.out_valid  = 1'b0;
    bus.sof_err    = 1'b0;
    bus.frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sof_xfer) begin
          w_pix_en     = 1'b1;
          w_state_next = FILL;
        end
      end
      FILL: begin
        if (w_xfer) begin
          w_pix_en = 1'b1;
          if (w_sof_xfer)
            bus.sof_err = 1'b1;
          else if (w_row_end && (w_vpos_cur == V_LAST))
            w_state_next = FLUSH;
          else if (w_row_end && (w_vpos_cur == FILL_LAST))
            w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_xfer) begin
          w_pix_en = 1'b1;
          if (w_sof_xfer) begin
            bus.sof_err  = 1'b1;
            w_state_next = FILL;
          end else begin
            bus.out_valid = 1'b1;
            if (w_row_end && (w_vpos_cur == V_LAST))
              w_state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Input is held off while zero rows push the last window rows out.
        w_pix_en      = 1'b1;
        bus.pad       = 1'b1;
        bus.out_valid = 1'b1;
        if (w_row_end && (w_vpos_cur == FLUSH_LAST))
          w_state_next = DONE;
      end
      DONE: begin
        bus.frame_done = 1'b1;
        w_state_next   = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_hpos_next    = r_hpos;
    w_vpos_next    = r_vpos;
    w_line_wr_next = r_line_wr;
    w_mode_next    = r_mode;
    if (w_sof_xfer)
      w_mode_next = (bus.cfg_mode == 2'b11) ? 2'b00 : bus.cfg_mode;
    if (w_pix_en) begin
      if (w_row_end) begin
        w_hpos_next    = '0;
        w_vpos_next    = w_vpos_cur + 11'd1;
        w_line_wr_next = (w_line_wr_cur == LW_LAST) ? 3'd0 : w_line_wr_cur + 3'd1;
      end else begin
        w_hpos_next    = w_hpos_cur + 11'd1;
        w_vpos_next    = w_vpos_cur;
        w_line_wr_next = w_line_wr_cur;
      end
    end
    if (w_state_next == DONE) begin
      w_hpos_next    = '0;
      w_vpos_next    = '0;
      w_line_wr_next = '0;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.pix_en      = w_pix_en;
  assign bus.hpos        = w_hpos_cur;
  assign bus.vpos        = w_vpos_cur;
  assign bus.line_wr     = w_line_wr_cur;
  assign bus.out_hpos    = w_hpos_cur;
  assign bus.out_vpos    = w_vpos_cur - LAG_W;
  assign bus.mode_active = r_mode;
endmodule

// File: tb/tb_morph_window_ctrl.sv
// Scoreboard bench for morph_window_ctrl at H=8, V=6, WIN_SIZE=5: driver pushes expected
// raster output coordinates per frame, a monitor pops them whenever out_valid is seen.
module tb_morph_window_ctrl;
  localparam int H   = 8;
  localparam int V   = 6;
  localparam int WIN = 5;
  localparam int LAG = WIN / 2 + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  morph_window_ctrl_if bus();

  morph_window_ctrl #(
    .H_IMG_RES(H),
    .V_IMG_RES(V),
    .WIN_SIZE (WIN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    int mode;
    bit pad;
  } exp_t;

  exp_t exp_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   pix_cnt  = 0;
  int   out_cnt  = 0;
  int   pad_cnt  = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endfunction

  // Reference: a frame (or the first n pixels of one) yields raster coordinates,
  // output lagging input by LAG rows; the last LAG rows come out of the zero-padded drain.
  task automatic push_outputs(int n_out, int mode);
    exp_t e;
    for (int k = 0; k < n_out; k++) begin
      e.row  = k / H;
      e.col  = k % H;
      e.mode = (mode == 3) ? 0 : mode;
      e.pad  = (e.row >= V - LAG);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_pixels(int n, int gap_mode, bit exp_err, int chg_at, logic [1:0] chg_mode);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        @(negedge clk);
        chk("gap_pix_en", bus.pix_en, 0);
        chk("gap_hold_hpos", bus.hpos, i % H);
      end
      @(posedge clk); #1;
      if (i == chg_at) bus.cfg_mode = chg_mode;
      bus.in_valid = 1'b1;
      bus.in_sof   = (i == 0);
      @(negedge clk);
      chk("hpos", bus.hpos, i % H);
      chk("vpos", bus.vpos, i / H);
      chk("line_wr", bus.line_wr, (i / H) % (WIN + 1));
      chk("pix_en", bus.pix_en, 1);
      chk("in_out_valid", bus.out_valid, (i >= LAG * H));
      if (i == 0) chk("sof_err", bus.sof_err, exp_err);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic wait_done(int snap);
    int t;
    t = 0;
    while (done_cnt == snap && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done_seen", done_cnt, snap + 1);
    repeat (4) @(negedge clk);
    chk("frame_done_once", done_cnt, snap + 1);
  endtask

  task automatic run_frame(logic [1:0] mode, int gap_mode, bit exp_err, int chg_at, logic [1:0] chg_mode);
    int p0, o0, d0, pd0;
    p0 = pix_cnt; o0 = out_cnt; d0 = done_cnt; pd0 = pad_cnt;
    push_outputs(H * V, int'(mode));
    bus.cfg_mode = mode;
    drive_pixels(H * V, gap_mode, exp_err, chg_at, chg_mode);
    wait_done(d0);
    chk("out_count", out_cnt - o0, H * V);
    chk("pad_count", pad_cnt - pd0, LAG * H);
    chk("fill_transfers", (pix_cnt - p0) - (out_cnt - o0), LAG * H);
    chk("mode_active", bus.mode_active, (mode == 2'b11) ? 0 : mode);
    chk("queue_empty", exp_q.size(), 0);
    $display("frame mode=%0d gaps=%0d outputs=%0d", mode, gap_mode, out_cnt - o0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.cfg_mode = 2'b00;
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (bus.pix_en)  pix_cnt++;
            if (bus.pad)     pad_cnt++;
            if (bus.sof_err) err_cnt++;
            if (bus.out_valid) begin
              out_cnt++;
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out_valid=1 at (%0d,%0d) required none",
                         bus.out_vpos, bus.out_hpos);
              end else begin
                e = exp_q.pop_front();
                chk("out_hpos", bus.out_hpos, e.col);
                chk("out_vpos", bus.out_vpos, e.row);
                chk("out_mode", bus.mode_active, e.mode);
                chk("out_pad", bus.pad, e.pad);
                $display("out row=%0d col=%0d mode=%0d pad=%0d", e.row, e.col, e.mode, e.pad);
              end
            end
            if (bus.frame_done) begin
              done_cnt++;
              chk("done_after_last_out", exp_q.size(), 0);
            end
          end
        end
      end
      begin : main
        int d0, t;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_pix_en", bus.pix_en, 0);
        chk("rst_hpos", bus.hpos, 0);
        chk("rst_vpos", bus.vpos, 0);
        chk("rst_line_wr", bus.line_wr, 0);
        chk("rst_mode", bus.mode_active, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // continuous frame, dilate
        run_frame(2'b01, 0, 1'b0, -1, 2'b00);
        // valid toggling every cycle
        run_frame(2'b01, 1, 1'b0, -1, 2'b00);

        // pixels without SOF in IDLE are dropped
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          bus.in_valid = 1'b1;
          bus.in_sof   = 1'b0;
          @(negedge clk);
          chk("idle_pix_en", bus.pix_en, 0);
          chk("idle_hpos", bus.hpos, 0);
          chk("idle_vpos", bus.vpos, 0);
          chk("idle_out_valid", bus.out_valid, 0);
        end
        run_frame(2'b01, 0, 1'b0, -1, 2'b00);

        // SOF at transfer 30 interrupts RUN
        bus.cfg_mode = 2'b01;
        d0 = done_cnt;
        push_outputs(30 - LAG * H, 1);
        drive_pixels(30, 0, 1'b0, -1, 2'b00);
        chk("partial_no_done", done_cnt, d0);
        run_frame(2'b01, 0, 1'b1, -1, 2'b00);

        // mode change mid-frame ignored until next SOF; reserved mode behaves as bypass
        run_frame(2'b01, 2, 1'b0, 10, 2'b10);
        run_frame(2'b10, 0, 1'b0, -1, 2'b00);
        run_frame(2'b11, 2, 1'b0, -1, 2'b00);

        // reset during FLUSH
        bus.cfg_mode = 2'b01;
        d0 = done_cnt;
        push_outputs(H * V, 1);
        drive_pixels(H * V, 0, 1'b0, -1, 2'b00);
        t = 0;
        while (!bus.pad && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("flush_reached", bus.pad, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_pix_en", bus.pix_en, 0);
        chk("midrst_hpos", bus.hpos, 0);
        chk("midrst_vpos", bus.vpos, 0);
        chk("midrst_mode", bus.mode_active, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", done_cnt, d0);
        run_frame(2'b10, 0, 1'b0, -1, 2'b00);

        chk("sof_err_count", err_cnt, 1);
      end
      begin : watchdog
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog: got still running required finished");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
